rw_arbiter: RTL and testbench
=============================

RW_ARBITER -- requirements
Module: rw_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- C_NASTI_ID_WIDTH, 9, transaction ID width.
- C_NASTI_ADDR_WIDTH, 32, byte address width.
- C_STARVE_LIMIT, 16, cycles that pending writes may wait before a write batch is forced (>=1).
- C_WR_BATCH, 4, maximum consecutive write grants in one batch (>=1).

REQ-002 Ports (name, direction, width, meaning):
- core_clk, in, 1, sole clock; one clock, all logic on rising edge.
- core_rst, in, 1, reset; synchronous and active-high.
- ar_addr/ar_id/ar_len, in, ADDR/ID/8, head entry of the read-address FIFO; first-word-fall-through, valid when rempty_ar=0.
- rempty_ar, in, 1, read-address FIFO empty.
- rinc_ar, out, 1, pop the read-address FIFO.
- aw_addr/aw_id/aw_len, in, ADDR/ID/8, head entry of the write-address FIFO; first-word-fall-through.
- rempty_aw, in, 1, write-address FIFO empty.
- rinc_aw, out, 1, pop the write-address FIFO.
- ref_req, in, 1, refresh request level from the refresh controller.
- ref_ack, out, 1, one-cycle pulse: refresh window granted.
- req_valid, out, 1, request register holds a request.
- req_ready, in, 1, address mapper / bank stage accepts.
- req_write, out, 1, 1 = write, 0 = read.
- req_addr/req_id/req_len, out, ADDR/ID/8, registered payload.

Function
REQ-003 Single request register. Load when (req_valid=0 OR req_valid&req_ready) AND a grant is made; a load sets req_valid=1 on the next edge.
REQ-004 Hold req_valid=1 with a stable payload until req_valid&req_ready; clear req_valid on accept if no load occurs that cycle.
REQ-005 Assert rinc_ar/rinc_aw combinationally for exactly the cycle in which the corresponding head entry is loaded; never both in one cycle; never when the selected FIFO is empty.
REQ-006 Timing: rinc pulse in cycle N; request visible at req_* in cycle N+1. Back-to-back requests sustain one per cycle when req_ready=1.
REQ-007 States: ARB, WBATCH, DRAIN, REFACK.
REQ-008 ARB:
- Grant a read if rempty_ar=0.
- Otherwise grant a write if rempty_aw=0.
- If starve_cnt==C_STARVE_LIMIT, go to WBATCH instead, clear starve_cnt, and make no read grant that cycle.
REQ-009 starve_cnt (saturating at C_STARVE_LIMIT) increments each ARB cycle in which rempty_aw=0 and no write is granted; it clears on any write grant.
REQ-010 WBATCH:
- Grant a write each loadable cycle while rempty_aw=0; count grants in batch_cnt.
- Return to ARB when batch_cnt reaches C_WR_BATCH or rempty_aw=1, clearing batch_cnt.
- Reads are not granted in WBATCH.
REQ-011 Refresh priority:
- Any state, when ref_req=1: go to DRAIN; no further grants from that cycle on, including the cycle ref_req is first seen.
- A write batch in progress is abandoned (batch_cnt cleared); starve_cnt is retained.
REQ-012 DRAIN: wait until req_valid=0 (after req_ready accepts the outstanding request), then go to REFACK.
REQ-013 REFACK: assert ref_ack=1 for one cycle, then go to ARB. If ref_req is still 1 in ARB, re-enter DRAIN and issue a further single ack.
REQ-014 Width rules:
- starve_cnt and batch_cnt are $clog2(limit+1) bits.
- No wrap: both counters saturate or clear, never roll over.
REQ-015 req_write is 1 exactly when the loaded entry came from the AW FIFO.

Reset
REQ-016 While core_rst=1 at an edge:
- state=ARB; req_valid=0; req_write=0; req_addr/req_id/req_len=0; starve_cnt=0; batch_cnt=0; ref_ack=0.
- rinc_ar=0 and rinc_aw=0 during reset cycles.
REQ-017 Reset asserted mid-operation discards the request register contents without popping any FIFO. The first grant is possible in the first cycle after core_rst deasserts.

Verification
REQ-018 Read and write FIFOs both non-empty, req_ready=1 -> reads granted each cycle; after 16 cycles of writes pending, a write batch of 4 consecutive req_write=1 follows, then reads resume.
REQ-019 req_ready=0 for 5 cycles with req_valid=1 -> req_addr/req_id/req_len stable; no rinc_ar/rinc_aw pulses; the single accept then pops exactly one new entry.
REQ-020 ref_req=1 while a request is held, req_ready=0 for 3 cycles -> no grants; ref_ack pulses exactly 1 cycle, in the cycle after the hold is accepted.
REQ-021 Only the AW FIFO is non-empty, with 2 entries -> two writes granted back-to-back (addresses in FIFO order), starve_cnt stays 0.
REQ-022 core_rst asserted for 1 cycle with req_valid=1 -> next cycle req_valid=0, no rinc pulses; a grant resumes the cycle after reset.
REQ-023 ref_req and a non-empty AR FIFO arrive in the same cycle, register empty -> no rinc_ar; ref_ack pulses 2 cycles later (DRAIN, then REFACK).

Source files
------------

// File: rtl/rw_arbiter.sv
// Read/write request arbiter feeding a single request register from the AR and AW FIFOs.
// Reads win by default; starved writes force a bounded write batch; refresh drains the register first.
module rw_arbiter #(
  parameter int C_NASTI_ID_WIDTH   = 9,
  parameter int C_NASTI_ADDR_WIDTH = 32,
  parameter int C_STARVE_LIMIT     = 16,
  parameter int C_WR_BATCH         = 4
) (
  input  logic                          core_clk,
  input  logic                          core_rst,
  input  logic [C_NASTI_ADDR_WIDTH-1:0] ar_addr,
  input  logic [C_NASTI_ID_WIDTH-1:0]   ar_id,
  input  logic [7:0]                    ar_len,
  input  logic                          rempty_ar,
  output logic                          rinc_ar,
  input  logic [C_NASTI_ADDR_WIDTH-1:0] aw_addr,
  input  logic [C_NASTI_ID_WIDTH-1:0]   aw_id,
  input  logic [7:0]                    aw_len,
  input  logic                          rempty_aw,
  output logic                          rinc_aw,
  input  logic                          ref_req,
  output logic                          ref_ack,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic                          req_write,
  output logic [C_NASTI_ADDR_WIDTH-1:0] req_addr,
  output logic [C_NASTI_ID_WIDTH-1:0]   req_id,
  output logic [7:0]                    req_len
);

  localparam int SW = $clog2(C_STARVE_LIMIT + 1);
  localparam int BW = $clog2(C_WR_BATCH + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(C_STARVE_LIMIT);
  localparam logic [BW-1:0] BATCH_LAST = BW'(C_WR_BATCH - 1);

  typedef enum logic [1:0] {ARB, WBATCH, DRAIN, REFACK} state_t;

  state_t                          state_reg, state_next;
  logic [SW-1:0]                   starve_cnt_reg, starve_cnt_next;
  logic [BW-1:0]                   batch_cnt_reg, batch_cnt_next;
  logic                            req_valid_reg;
  logic                            req_write_reg;
  logic [C_NASTI_ADDR_WIDTH-1:0]   req_addr_reg;
  logic [C_NASTI_ID_WIDTH-1:0]     req_id_reg;
  logic [7:0]                      req_len_reg;
  logic                            load_ok;
  logic                            grant_rd;
  logic                            grant_wr;

  // The register can take a new entry when empty or when its occupant leaves this cycle.
  assign load_ok = !req_valid_reg || req_ready;

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    batch_cnt_next  = batch_cnt_reg;
    grant_rd        = 1'b0;
    grant_wr        = 1'b0;
    if (!core_rst) begin
      case (state_reg)
        ARB: begin
          if (ref_req) begin
            state_next = DRAIN;
          end else if (starve_cnt_reg == STARVE_MAX) begin
            state_next      = WBATCH;
            starve_cnt_next = '0;
          end else begin
            if (!rempty_ar && load_ok) begin
              grant_rd = 1'b1;
            end else if (!rempty_aw && load_ok) begin
              grant_wr = 1'b1;
            end
            if (grant_wr) begin
              starve_cnt_next = '0;
            end else if (!rempty_aw && starve_cnt_reg != STARVE_MAX) begin
              starve_cnt_next = starve_cnt_reg + 1'b1;
            end
          end
        end
        WBATCH: begin
          if (ref_req) begin
            state_next     = DRAIN;
            batch_cnt_next = '0;
          end else if (rempty_aw) begin
            state_next     = ARB;
            batch_cnt_next = '0;
          end else if (load_ok) begin
            grant_wr        = 1'b1;
            starve_cnt_next = '0;
            // The final grant of a batch hands control straight back to ARB.
            if (batch_cnt_reg == BATCH_LAST) begin
              state_next     = ARB;
              batch_cnt_next = '0;
            end else begin
              batch_cnt_next = batch_cnt_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (load_ok) begin
            state_next = REFACK;
          end
        end
        REFACK: begin
          state_next = ARB;
        end
        default: begin
          state_next = ARB;
        end
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_reg      <= ARB;
      starve_cnt_reg <= '0;
      batch_cnt_reg  <= '0;
      req_valid_reg  <= 1'b0;
      req_write_reg  <= 1'b0;
      req_addr_reg   <= '0;
      req_id_reg     <= '0;
      req_len_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      batch_cnt_reg  <= batch_cnt_next;
      if (grant_rd || grant_wr) begin
        req_valid_reg <= 1'b1;
        req_write_reg <= grant_wr;
        req_addr_reg  <= grant_wr ? aw_addr : ar_addr;
        req_id_reg    <= grant_wr ? aw_id : ar_id;
        req_len_reg   <= grant_wr ? aw_len : ar_len;
      end else if (req_ready) begin
        req_valid_reg <= 1'b0;
      end
    end
  end

  assign rinc_ar   = grant_rd;
  assign rinc_aw   = grant_wr;
  assign ref_ack   = (state_reg == REFACK);
  assign req_valid = req_valid_reg;
  assign req_write = req_write_reg;
  assign req_addr  = req_addr_reg;
  assign req_id    = req_id_reg;
  assign req_len   = req_len_reg;

endmodule

// File: tb/tb_rw_arbiter.sv
// Randomized scoreboard bench for rw_arbiter: FIFO models feed the DUT, a policy model predicts
// pops and acks, and a separate monitor checks each accepted request against the expected queue.
module tb_rw_arbiter;

  localparam int LIMIT = 16;
  localparam int WB    = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [8:0]  id;
    logic [7:0]  len;
  } ent_t;

  typedef struct packed {
    logic wr;
    ent_t e;
  } exp_t;

  logic        core_clk = 1'b0;
  logic        core_rst = 1'b1;
  logic [31:0] ar_addr = '0;
  logic [8:0]  ar_id = '0;
  logic [7:0]  ar_len = '0;
  logic        rempty_ar = 1'b1;
  logic        rinc_ar;
  logic [31:0] aw_addr = '0;
  logic [8:0]  aw_id = '0;
  logic [7:0]  aw_len = '0;
  logic        rempty_aw = 1'b1;
  logic        rinc_aw;
  logic        ref_req = 1'b0;
  logic        ref_ack;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_write;
  logic [31:0] req_addr;
  logic [8:0]  req_id;
  logic [7:0]  req_len;

  rw_arbiter #(
    .C_NASTI_ID_WIDTH(9), .C_NASTI_ADDR_WIDTH(32), .C_STARVE_LIMIT(LIMIT), .C_WR_BATCH(WB)
  ) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len), .rempty_ar(rempty_ar), .rinc_ar(rinc_ar),
    .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len), .rempty_aw(rempty_aw), .rinc_aw(rinc_aw),
    .ref_req(ref_req), .ref_ack(ref_ack),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_id(req_id), .req_len(req_len)
  );

  always #5 core_clk = ~core_clk;

  ent_t ar_q[$];
  ent_t aw_q[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference policy state: register occupancy, refresh phase, writes left in a batch, write wait time.
  bit m_valid = 0;
  bit m_drain = 0;
  bit m_ack   = 0;
  int m_batch_left = 0;
  int m_wait = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.addr = $urandom;
    e.id   = 9'($urandom_range(0, 511));
    e.len  = 8'($urandom_range(0, 255));
    return e;
  endfunction

  // One clock cycle: drive inputs at the falling edge, predict and compare the combinational outputs,
  // then advance the reference model to what the next rising edge should produce.
  task automatic run_cycle(input bit rst, input bit rdy, input bit rf, input bit p_ar, input bit p_aw,
                           output int kind);
    bit g_r, g_w, exp_ack, loadable;
    exp_t x;
    @(negedge core_clk);
    if (p_ar) ar_q.push_back(rand_ent());
    if (p_aw) aw_q.push_back(rand_ent());
    core_rst  = rst;
    req_ready = rdy;
    ref_req   = rf;
    rempty_ar = (ar_q.size() == 0);
    rempty_aw = (aw_q.size() == 0);
    if (ar_q.size() > 0) begin
      ar_addr = ar_q[0].addr; ar_id = ar_q[0].id; ar_len = ar_q[0].len;
    end
    if (aw_q.size() > 0) begin
      aw_addr = aw_q[0].addr; aw_id = aw_q[0].id; aw_len = aw_q[0].len;
    end
    #1;
    g_r = 0;
    g_w = 0;
    exp_ack  = m_ack;
    loadable = !m_valid || rdy;
    if (!rst) begin
      if (m_ack) begin
        m_ack = 0;
      end else if (m_drain) begin
        if (loadable) begin
          m_drain = 0;
          m_ack = 1;
        end
      end else if (rf) begin
        m_drain = 1;
        m_batch_left = 0;
      end else if (m_batch_left > 0) begin
        if (aw_q.size() == 0) m_batch_left = 0;
        else if (loadable) begin
          g_w = 1;
          m_batch_left--;
        end
      end else if (m_wait == LIMIT) begin
        m_batch_left = WB;
        m_wait = 0;
      end else begin
        if (ar_q.size() > 0 && loadable) g_r = 1;
        else if (aw_q.size() > 0 && loadable) g_w = 1;
        if (aw_q.size() > 0 && !g_w && m_wait < LIMIT) m_wait++;
      end
      if (g_w) m_wait = 0;
    end
    kind = rinc_ar ? 1 : (rinc_aw ? 2 : 0);
    check("rinc_ar", rinc_ar, g_r);
    check("rinc_aw", rinc_aw, g_w);
    check("ref_ack", ref_ack, exp_ack);
    check("req_valid", req_valid, m_valid);
    if (rst) begin
      m_valid = 0; m_drain = 0; m_ack = 0; m_batch_left = 0; m_wait = 0;
      exp_q.delete();
    end else if (g_r) begin
      x.wr = 1'b0;
      x.e  = ar_q.pop_front();
      exp_q.push_back(x);
      m_valid = 1;
    end else if (g_w) begin
      x.wr = 1'b1;
      x.e  = aw_q.pop_front();
      exp_q.push_back(x);
      m_valid = 1;
    end else if (rdy) begin
      m_valid = 0;
    end
  endtask

  // Monitor: every accepted request must match the oldest outstanding grant.
  initial begin
    exp_t x;
    forever begin
      @(negedge core_clk);
      #2;
      if (!core_rst && req_valid === 1'b1 && req_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL accept_unexpected: actual=accept of addr %0h required=no request outstanding", req_addr);
        end else begin
          x = exp_q.pop_front();
          check("req_write", req_write, x.wr);
          check("req_addr", req_addr, x.e.addr);
          check("req_id", req_id, x.e.id);
          check("req_len", req_len, x.e.len);
        end
      end
    end
  end

  initial begin
    int kind, want, ref_hold, pa, pw, pr;
    bit rst, rf;
    for (int i = 0; i < 3; i++) run_cycle(1, 0, 0, 0, 0, kind);
    run_cycle(0, 0, 0, 0, 0, kind);
    check("reset_req_write", req_write, 0);
    check("reset_req_addr", req_addr, 0);
    check("reset_req_id", req_id, 0);
    check("reset_req_len", req_len, 0);

    // Both FIFOs loaded, sink always ready: 16 reads, one switch cycle, a 4-write batch, reads again.
    for (int i = 0; i < 30; i++) begin
      ar_q.push_back(rand_ent());
      aw_q.push_back(rand_ent());
    end
    for (int c = 0; c < 25; c++) begin
      run_cycle(0, 1, 0, 0, 0, kind);
      want = (c < LIMIT) ? 1 : (c == LIMIT) ? 0 : (c <= LIMIT + WB) ? 2 : 1;
      check("batch_seq", kind, want);
    end

    // Held request under back-pressure, then a single accept.
    for (int i = 0; i < 5; i++) run_cycle(0, 0, 0, 0, 0, kind);
    run_cycle(0, 1, 0, 0, 0, kind);

    // Refresh while a request is held and the sink stalls for 3 cycles.
    run_cycle(0, 0, 1, 0, 0, kind);
    for (int i = 0; i < 2; i++) run_cycle(0, 0, 1, 0, 0, kind);
    for (int i = 0; i < 4; i++) run_cycle(0, 1, 0, 0, 0, kind);

    // Reset for one cycle with a request held.
    run_cycle(0, 0, 0, 0, 0, kind);
    run_cycle(1, 0, 0, 0, 0, kind);
    run_cycle(0, 1, 0, 0, 0, kind);
    check("post_reset_grant", kind, 1);

    // Drain everything, then writes only: two back-to-back writes in FIFO order.
    for (int i = 0; i < 80; i++) run_cycle(0, 1, 0, 0, 0, kind);
    aw_q.push_back(rand_ent());
    aw_q.push_back(rand_ent());
    run_cycle(0, 1, 0, 0, 0, kind);
    check("aw_only_first", kind, 2);
    run_cycle(0, 1, 0, 0, 0, kind);
    check("aw_only_second", kind, 2);

    // Refresh and a read arrive together with an empty register.
    for (int i = 0; i < 3; i++) run_cycle(0, 1, 0, 0, 0, kind);
    run_cycle(0, 1, 1, 1, 0, kind);
    check("ref_first_no_read", kind, 0);
    run_cycle(0, 1, 0, 0, 0, kind);
    run_cycle(0, 1, 0, 0, 0, kind);
    check("ref_ack_two_later", ref_ack, 1);

    // Randomized traffic with refresh bursts and occasional resets.
    ref_hold = 0;
    pa = 30; pw = 30; pr = 70;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        pa = $urandom_range(10, 80);
        pw = $urandom_range(10, 80);
        pr = $urandom_range(30, 100);
      end
      rst = ($urandom_range(0, 299) == 0);
      rf = 0;
      if (ref_hold > 0) begin
        rf = 1;
        ref_hold--;
      end else if ($urandom_range(0, 59) == 0) begin
        ref_hold = $urandom_range(1, 6);
      end
      run_cycle(rst, ($urandom_range(0, 99) < pr),
                rf, ($urandom_range(0, 99) < pa) && ar_q.size() < 12,
                ($urandom_range(0, 99) < pw) && aw_q.size() < 12, kind);
    end

    for (int i = 0; i < 200; i++) run_cycle(0, 1, 0, 0, 0, kind);
    check("scoreboard_empty", exp_q.size(), 0);
    check("fifos_drained", ar_q.size() + aw_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
